// File: rtl/cpu_mem.sv
// cpu_mem: unified 16-bit program/data RAM with combinational reads and a byte-stream program
// loader that holds the core. Define CPU_MEM_MMIO_EN to add the FF00/FF02 MMIO output FIFO.
module cpu_mem #(
    parameter int ADDR_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    input  logic        write_enable,
    output logic [15:0] rd_data,
    output logic        cpu_hold,
    input  logic        ld_start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);
    localparam int WORDS = 1 << ADDR_BITS;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD_LO = 2'd1;
    localparam logic [1:0] ST_LOAD_HI = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [15:0]          mem [WORDS];
    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [7:0]           low_q, low_d;
    logic                 ld_accept;
    logic                 ld_wr;
    logic [15:0]          ld_wr_data;
    logic [ADDR_BITS-1:0] cpu_idx;
    logic                 ram_sel;
    logic                 cpu_wr;
    logic [15:0]          ram_rd;

    assign cpu_idx   = addr[ADDR_BITS:1];
    assign ld_ready  = (state_q == ST_LOAD_LO) || (state_q == ST_LOAD_HI);
    assign cpu_hold  = (state_q != ST_IDLE);
    assign ld_accept = ld_valid && ld_ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        low_d      = low_q;
        ld_wr      = 1'b0;
        ld_wr_data = {8'h00, ld_byte};
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD_LO;
                    ptr_d   = '0;
                end
            end
            ST_LOAD_LO: begin
                if (ld_accept) begin
                    if (ld_last) begin
                        ld_wr   = 1'b1;
                        state_d = ST_RELEASE;
                    end else begin
                        low_d   = ld_byte;
                        state_d = ST_LOAD_HI;
                    end
                end
            end
            ST_LOAD_HI: begin
                if (ld_accept) begin
                    ld_wr      = 1'b1;
                    ld_wr_data = {ld_byte, low_q};
                    ptr_d      = ptr_q + ADDR_BITS'(1);
                    state_d    = ld_last ? ST_RELEASE : ST_LOAD_LO;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            low_q   <= low_d;
        end
    end

    // The loader owns the write port while the core is held, so core stores are dropped then.
    assign cpu_wr = write_enable && !cpu_hold && ram_sel;

    always_ff @(posedge clock) begin
        if (ld_wr) begin
            mem[ptr_q] <= ld_wr_data;
        end else if (cpu_wr) begin
            mem[cpu_idx] <= wr_data;
        end
    end

    assign ram_rd = mem[cpu_idx];

`ifdef CPU_MEM_MMIO_EN
    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q;
    logic          ovf_q;
    logic          is_data, is_stat, full, flush;
    logic          push_req, push, pop, core_st;

    assign is_data  = (addr == 16'hFF00);
    assign is_stat  = (addr == 16'hFF02);
    assign ram_sel  = !(is_data || is_stat);
    assign full     = (count_q == DEPTH_C);
    assign flush    = (state_q == ST_IDLE) && ld_start;
    assign core_st  = write_enable && !cpu_hold;
    assign push_req = core_st && is_data;
    assign push     = push_req && !full && !flush;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
            if (push_req && full) begin
                ovf_q <= 1'b1;
            end else if (core_st && is_stat) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= wr_data;
    end

    assign out_valid = (count_q != 5'd0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : 16'h0000;

    always_comb begin
        rd_data = ram_rd;
        if (is_data) begin
            rd_data = 16'h0000;
        end else if (is_stat) begin
            rd_data = {ovf_q, full, 9'b0, count_q};
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{addr, out_ready};
    assign ram_sel       = 1'b1;
    assign out_valid     = 1'b0;
    assign out_data      = 16'h0000;
    assign rd_data       = ram_rd;
`endif

endmodule

// File: tb/tb_cpu_mem.sv
// Randomised scoreboard bench for cpu_mem: the driver pushes expected read/pop values from a
// word-array + queue reference model; a negedge monitor pops and compares them.
module tb_cpu_mem;
    localparam int AB    = 8;
    localparam int DEPTH = 4;
    localparam int WORDS = 1 << AB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wr_data = 16'h0;
    logic        write_enable = 1'b0;
    logic [15:0] rd_data;
    logic        cpu_hold;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [7:0]  ld_byte = 8'h0;
    logic        ld_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;

    always #5 clock = ~clock;

    cpu_mem #(.ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .addr(addr), .wr_data(wr_data),
        .write_enable(write_enable), .rd_data(rd_data), .cpu_hold(cpu_hold),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_byte(ld_byte), .ld_last(ld_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] mdl [WORDS];
    logic [15:0] fifo_m [$];
    logic        ovf_m = 1'b0;
    logic [15:0] rd_q [$];
    logic        rd_tag = 1'b0;
    logic        exp_hold = 1'b0;
    logic        exp_ready = 1'b0;
    logic [7:0]  bq [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return int'(a[AB:1]);
    endfunction

    function automatic logic is_mmio(input logic [15:0] a);
`ifdef CPU_MEM_MMIO_EN
        return (a == 16'hFF00) || (a == 16'hFF02);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
`ifdef CPU_MEM_MMIO_EN
        logic full_m;
        full_m = (fifo_m.size() == DEPTH);
        if (a == 16'hFF00) return 16'h0000;
        if (a == 16'hFF02) return {ovf_m, full_m, 9'b0, 5'(fifo_m.size())};
`endif
        return mdl[widx(a)];
    endfunction

    // Monitor: control outputs every cycle, tagged reads, and FIFO pops.
    always @(negedge clock) begin
        logic [15:0] e;
        logic        vexp;
        chk("hold_ready", {14'd0, cpu_hold, ld_ready}, {14'd0, exp_hold, exp_ready});
        if (rd_tag) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_empty", 16'(rd_q.size()), 16'd1);
            end else begin
                e = rd_q.pop_front();
                chk("rd_data", rd_data, e);
            end
        end
`ifdef CPU_MEM_MMIO_EN
        vexp = (fifo_m.size() != 0);
        chk("out_valid", {15'd0, out_valid}, {15'd0, vexp});
        if (!out_valid) chk("out_data_idle", out_data, 16'h0000);
        if (out_valid && out_ready && vexp) begin
            e = fifo_m.pop_front();
            chk("out_data", out_data, e);
            $display("pop %h", out_data);
        end
`else
        vexp = 1'b0;
        chk("out_off", {out_valid, out_data[14:0]}, {vexp, 15'd0});
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_store(input logic [15:0] a, input logic [15:0] d);
`ifdef CPU_MEM_MMIO_EN
        if (a == 16'hFF00) begin
            if (fifo_m.size() == DEPTH) ovf_m = 1'b1;
            else fifo_m.push_back(d);
            return;
        end
        if (a == 16'hFF02) begin
            ovf_m = 1'b0;
            return;
        end
`endif
        mdl[widx(a)] = d;
    endtask

    // A store cycle also checks that the same-cycle read still shows the old data.
    task automatic cpu_store(input logic [15:0] a, input logic [15:0] d);
        addr = a; wr_data = d; write_enable = 1'b1;
        rd_q.push_back(model_read(a)); rd_tag = 1'b1;
        tick();
        write_enable = 1'b0; rd_tag = 1'b0;
        apply_store(a, d);
        $display("store [%h] <= %h", a, d);
    endtask

    task automatic cpu_read(input logic [15:0] a);
        addr = a;
        rd_q.push_back(model_read(a)); rd_tag = 1'b1;
        tick();
        rd_tag = 1'b0;
        $display("read [%h] expect %h", a, model_read(a));
    endtask

    task automatic noise_cycle();
        ld_start = 1'($urandom_range(0, 1));
        write_enable = 1'b1;
        addr = 16'($urandom_range(0, 1023));
        wr_data = 16'($urandom);
        tick();
        ld_start = 1'b0; write_enable = 1'b0;
    endtask

    // Loads bq; abort_at >= 0 pulls reset right after that byte is accepted.
    task automatic do_load(input int abort_at);
        logic [7:0] ptr_m;
        int         n;
        n = bq.size();
        ld_valid = 1'b1; ld_byte = 8'h5A; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        exp_hold = 1'b1; exp_ready = 1'b1; ptr_m = '0;
        fifo_m.delete(); ovf_m = 1'b0;
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) noise_cycle();
            ld_valid = 1'b1; ld_byte = bq[i]; ld_last = (i == n - 1);
            tick();
            ld_valid = 1'b0; ld_last = 1'b0;
            if (i % 2 == 1) begin
                mdl[ptr_m] = {bq[i], bq[i-1]};
                ptr_m++;
            end else if (i == n - 1) begin
                mdl[ptr_m] = {8'h00, bq[i]};
            end
            if (i == abort_at) begin
                reset = 1'b0; exp_hold = 1'b0; exp_ready = 1'b0;
                fifo_m.delete(); ovf_m = 1'b0;
                tick();
                reset = 1'b1;
                $display("load of %0d bytes aborted by reset after byte %0d", n, i);
                return;
            end
        end
        exp_ready = 1'b0;
        noise_cycle();
        exp_hold = 1'b0;
        $display("load of %0d bytes done", n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        tick();
        chk("reset_out_data", out_data, 16'h0000);
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < WORDS; i++) cpu_store(16'(i * 2), 16'($urandom));

        bq.delete(); bq.push_back(8'h08); bq.push_back(8'h41); bq.push_back(8'h0E); bq.push_back(8'h00);
        do_load(-1);
        cpu_read(16'h0000); cpu_read(16'h0002);

        bq.delete(); bq.push_back(8'hAA); bq.push_back(8'hBB); bq.push_back(8'hCC);
        do_load(-1);
        cpu_read(16'h0000); cpu_read(16'h0002);

        cpu_store(16'h0010, 16'h1234);
        cpu_read(16'h0010); cpu_read(16'h0210);

`ifdef CPU_MEM_MMIO_EN
        for (int k = 0; k < 5; k++) cpu_store(16'hFF00, 16'(16'hA000 + k));
        cpu_read(16'hFF02);
        cpu_store(16'hFF02, 16'h0000);
        cpu_read(16'hFF02);
        cpu_read(16'hFF00);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && fifo_m.size() != 0; k++) tick();
        out_ready = 1'b0;
        chk("drain1_left", 16'(fifo_m.size()), 16'd0);
        cpu_store(16'hFF00, 16'hB001); cpu_store(16'hFF00, 16'hB002);
        out_ready = 1'b1;
        cpu_store(16'hFF00, 16'hB003);
        out_ready = 1'b0;
        cpu_read(16'hFF02);
        out_ready = 1'b1;
        for (int k = 0; k < 10 && fifo_m.size() != 0; k++) tick();
        out_ready = 1'b0;
        chk("drain2_left", 16'(fifo_m.size()), 16'd0);
        for (int k = 0; k < 6; k++) cpu_store(16'hFF00, 16'(16'hC000 + k));
        bq.delete(); bq.push_back(8'h11);
        do_load(-1);
        cpu_read(16'hFF02);
`else
        cpu_store(16'hFF00, 16'hBEEF);
        cpu_read(16'hFF00); cpu_read(16'h0100);
        cpu_store(16'hFF02, 16'h5150);
        cpu_read(16'hFF02);
`endif

        bq.delete();
        for (int k = 0; k < 6; k++) bq.push_back(8'($urandom));
        do_load(2);
        cpu_read(16'h0000); cpu_read(16'h0002);

        bq.delete();
        for (int k = 0; k < 516; k++) bq.push_back(8'($urandom));
        do_load(-1);
        cpu_read(16'h0000); cpu_read(16'h0002); cpu_read(16'h0004); cpu_read(16'h01FE);

        for (int it = 0; it < 150; it++) begin
            a = 16'($urandom);
            if (is_mmio(a)) a = a & 16'h00FF;
            case ($urandom_range(0, 4))
                0, 1: cpu_store(a, 16'($urandom));
                2, 3: cpu_read(a);
                default: begin
                    bq.delete();
                    for (int k = 0; k < int'($urandom_range(1, 9)); k++) bq.push_back(8'($urandom));
                    do_load(-1);
                    cpu_read(16'h0000); cpu_read(16'h0002);
                end
            endcase
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
